tilt_ball_integrator: RTL

//  Physics stage between the accelerometer SPI reader and the VGA renderer. Latches each signed 8-bit X/Y tilt sample.
//  On every frame tick it integrates tilt into velocity and velocity into a fixed-point ball position.
//  It then clamps the ball to the screen with a damped bounce and publishes xcenter/ycenter to the VGA stage.

---
 rtl/labyrinth_pkg.sv | 43 ++++
 rtl/axis_integrator.sv | 107 ++++++++++
 rtl/tilt_ball_integrator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/labyrinth_pkg.sv
// Shared constants, FSM state type and the saturating velocity adder for the
// tilt-ball physics stage.
package labyrinth_pkg;

    localparam int H_ACTIVE     = 1280;  // visible pixels per line
    localparam int V_ACTIVE     = 1024;  // visible lines per frame
    localparam int BALL_R       = 16;    // ball radius in pixels
    localparam int FRAC         = 4;     // sub-pixel bits of position
    localparam int VW           = 12;    // signed velocity width
    localparam int VMAX         = 400;   // velocity saturation magnitude
    localparam int DEADZONE     = 4;     // |tilt| at or below this reads as 0
    localparam int BOUNCE_SHIFT = 2;     // wall bounce keeps v/4, reversed
    localparam int TILT_W       = 8;     // accelerometer sample width

    // Saturation limits at the widened adder width.
    localparam logic signed [VW:0] VLIM   = (VW + 1)'(VMAX);
    localparam logic signed [VW:0] VLIM_N = -VLIM;

    typedef enum logic [1:0] {
        IDLE,
        VEL,
        POS,
        CLAMP
    } phys_state_t;

    // v + a evaluated one bit wider than v so the sum cannot wrap, then
    // clipped to +/-VMAX.
    function automatic logic signed [VW-1:0] sat_add(
        input logic signed [VW-1:0]     v,
        input logic signed [TILT_W-1:0] a
    );
        logic signed [VW:0] sum;
        sum = (VW + 1)'(v) + (VW + 1)'(a);
        if (sum > VLIM) begin
            sat_add = VLIM[VW-1:0];
        end else if (sum < VLIM_N) begin
            sat_add = VLIM_N[VW-1:0];
        end else begin
            sat_add = sum[VW-1:0];
        end
    endfunction

endpackage

// File: rtl/axis_integrator.sv
// One axis of the ball physics: tilt deadzone, velocity integration with
// saturation, position integration and wall clamp with damped bounce.
// The parent FSM sequences the steps through the do_* strobes.
module axis_integrator
    import labyrinth_pkg::*;
#(
    parameter int EXTENT = H_ACTIVE,
    parameter int OUT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              recenter,
    input  logic [TILT_W-1:0] tilt_raw,
    output logic [TILT_W-1:0] tilt_dz,
    input  logic [TILT_W-1:0] tilt_lat,
    input  logic              start,
    input  logic              do_vel,
    input  logic              do_pos,
    input  logic              do_clamp,
    output logic [OUT_W-1:0]  center_px,
    output logic              hit_lo,
    output logic              hit_hi
);

    // Position carries two spare bits above the pixel range so an overshoot
    // past either wall is still representable (negative or above EXTENT).
    localparam int PW  = OUT_W + FRAC;
    localparam int PSW = PW + 2;

    localparam logic signed [PSW-1:0] P_CENTRE = PSW'((EXTENT / 2) << FRAC);
    localparam logic signed [PSW-1:0] P_LO     = PSW'(BALL_R << FRAC);
    localparam logic signed [PSW-1:0] P_HI     = PSW'((EXTENT - 1 - BALL_R) << FRAC);

    localparam logic signed [TILT_W-1:0] DZ_P = TILT_W'(DEADZONE);
    localparam logic signed [TILT_W-1:0] DZ_N = -DZ_P;

    logic signed [PSW-1:0]    pos;
    logic signed [PSW-1:0]    pos_step;
    logic signed [PSW-1:0]    pos_clamped;
    logic signed [VW-1:0]     vel;
    logic signed [VW-1:0]     vel_bounce;
    logic signed [TILT_W-1:0] a_frame;
    logic                     lo;
    logic                     hi;

    // Small tilts from a resting board are noise; flatten them to zero.
    function automatic logic [TILT_W-1:0] deadzone(input logic signed [TILT_W-1:0] t);
        if ((t <= DZ_P) && (t >= DZ_N)) begin
            deadzone = '0;
        end else begin
            deadzone = t;
        end
    endfunction

    assign tilt_dz    = deadzone(tilt_raw);
    assign pos_step   = pos + PSW'(vel);
    assign vel_bounce = -(vel >>> BOUNCE_SHIFT);
    assign center_px  = pos_clamped[FRAC +: OUT_W];
    assign hit_lo     = lo;
    assign hit_hi     = hi;

    // Wall test on the freshly integrated position; only one side can trip
    // because the ball is much smaller than the screen.
    always_comb begin
        pos_clamped = pos;
        lo          = 1'b0;
        hi          = 1'b0;
        if (pos < P_LO) begin
            pos_clamped = P_LO;
            lo          = 1'b1;
        end else if (pos > P_HI) begin
            pos_clamped = P_HI;
            hi          = 1'b1;
        end
    end

    // Physics state: frame tilt snapshot, velocity and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= P_CENTRE;
            vel     <= '0;
            a_frame <= '0;
        end else if (recenter) begin
            pos <= P_CENTRE;
            vel <= '0;
        end else begin
            // Snapshot taken as the frame starts, so a sample landing on the
            // same edge or mid-update waits for the following frame.
            if (start) begin
                a_frame <= tilt_lat;
            end
            if (do_vel) begin
                vel <= sat_add(vel, a_frame);
            end
            if (do_pos) begin
                pos <= pos_step;
            end
            if (do_clamp) begin
                pos <= pos_clamped;
                if (lo || hi) begin
                    vel <= vel_bounce;
                end
            end
        end
    end

endmodule

// File: rtl/tilt_ball_integrator.sv
// Ball physics stage between the accelerometer reader and the VGA renderer.
// Latches tilt samples, runs one integrate/clamp pass per frame tick and
// publishes both centre coordinates together on the same edge.
module tilt_ball_integrator
    import labyrinth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [7:0]  xdata,
    input  logic [7:0]  ydata,
    input  logic        frame_tick,
    input  logic        recenter,
    output logic [10:0] xcenter,
    output logic [9:0]  ycenter,
    output logic [3:0]  wall_hit,
    output logic        update_done
);

    localparam logic [10:0] X_MID = 11'(H_ACTIVE / 2);
    localparam logic [9:0]  Y_MID = 10'(V_ACTIVE / 2);

    phys_state_t       state;
    logic              pending;
    logic [TILT_W-1:0] ax;
    logic [TILT_W-1:0] ay;
    logic [TILT_W-1:0] ax_dz;
    logic [TILT_W-1:0] ay_dz;
    logic [10:0]       x_px;
    logic [9:0]        y_px;
    logic              x_lo;
    logic              x_hi;
    logic              y_lo;
    logic              y_hi;
    logic              start;
    logic              do_vel;
    logic              do_pos;
    logic              do_clamp;

    // Both axes step in lockstep off the single FSM.
    assign start    = (state == IDLE) && (frame_tick || pending);
    assign do_vel   = (state == VEL);
    assign do_pos   = (state == POS);
    assign do_clamp = (state == CLAMP);

    axis_integrator #(
        .EXTENT (H_ACTIVE),
        .OUT_W  (11)
    ) u_axis_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .recenter  (recenter),
        .tilt_raw  (xdata),
        .tilt_dz   (ax_dz),
        .tilt_lat  (ax),
        .start     (start),
        .do_vel    (do_vel),
        .do_pos    (do_pos),
        .do_clamp  (do_clamp),
        .center_px (x_px),
        .hit_lo    (x_lo),
        .hit_hi    (x_hi)
    );

    axis_integrator #(
        .EXTENT (V_ACTIVE),
        .OUT_W  (10)
    ) u_axis_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .recenter  (recenter),
        .tilt_raw  (ydata),
        .tilt_dz   (ay_dz),
        .tilt_lat  (ay),
        .start     (start),
        .do_vel    (do_vel),
        .do_pos    (do_pos),
        .do_clamp  (do_clamp),
        .center_px (y_px),
        .hit_lo    (y_lo),
        .hit_hi    (y_hi)
    );

    // Tilt latch: accepts a new deadzoned sample pair in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax <= '0;
            ay <= '0;
        end else if (sample_valid) begin
            ax <= ax_dz;
            ay <= ay_dz;
        end
    end

    // Frame sequencer with one-deep tick queue and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            xcenter     <= X_MID;
            ycenter     <= Y_MID;
            wall_hit    <= '0;
            update_done <= 1'b0;
        end else if (recenter) begin
            state       <= IDLE;
            pending     <= 1'b0;
            xcenter     <= X_MID;
            ycenter     <= Y_MID;
            wall_hit    <= '0;
            update_done <= 1'b0;
        end else begin
            wall_hit    <= '0;
            update_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick || pending) begin
                        state   <= VEL;
                        pending <= 1'b0;
                    end
                end
                VEL: begin
                    state <= POS;
                    if (frame_tick) begin
                        pending <= 1'b1;
                    end
                end
                POS: begin
                    state <= CLAMP;
                    if (frame_tick) begin
                        pending <= 1'b1;
                    end
                end
                CLAMP: begin
                    state       <= IDLE;
                    xcenter     <= x_px;
                    ycenter     <= y_px;
                    wall_hit    <= {y_hi, y_lo, x_hi, x_lo};
                    update_done <= 1'b1;
                    if (frame_tick) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
